// File: rtl/sr_trace_if.sv
// Retire-trace bus: the retire sample stream into the trace buffer and the drain port out of it.
// Drain handshake: an entry moves when out_valid && out_ready are both high at a clock edge.
// out_valid never depends on out_ready, and out_* stay stable while out_valid is high and the entry has not moved.
interface sr_trace_if;
  logic        trig_valid;
  logic [31:0] trig_pc;
  logic [31:0] trig_instr;
  logic [31:0] trig_a0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cycle;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_a0;

  modport master (
    output trig_valid, trig_pc, trig_instr, trig_a0, out_ready,
    input  out_valid, out_cycle, out_pc, out_instr, out_a0
  );

  modport slave (
    input  trig_valid, trig_pc, trig_instr, trig_a0, out_ready,
    output out_valid, out_cycle, out_pc, out_instr, out_a0
  );
endinterface

// File: rtl/sr_trace_buf.sv
// Retire-trace capture buffer: records the last 2^DEPTH_LOG2 retires in a ring, freezes on
// watchdog or request, then drains oldest-first over the bus drain port.
module sr_trace_buf #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_trace_if.slave             bus,
  input  logic                  freeze,
  input  logic                  restart,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  timeout,
  output logic [1:0]            state_o
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = '0;
  localparam logic [15:0]         WD_STAMP  = 16'(TIMEOUT_CYCLES);
  localparam logic                WD_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state;
  state_t                nextState;
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [15:0]           cyc;
  logic [111:0]          mem [DEPTH];
  logic                  drainValid;
  logic                  capture;
  logic                  xfer;
  logic                  wdFire;

  assign drainValid = (state == DRAIN) && (count != CNT_ZERO);
  assign capture    = (state == CAPTURE) && bus.trig_valid;
  assign xfer       = drainValid && bus.out_ready;
  assign wdFire     = WD_EN && (state == CAPTURE) && (cyc == WD_STAMP);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CAPTURE;
    else        state <= nextState;
  end

  // Next-state logic; restart wins over freeze, watchdog and drain progress.
  always_comb begin
    nextState = state;
    if (restart) begin
      nextState = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (wdFire || freeze) nextState = DRAIN;
        DRAIN:   if ((count == CNT_ZERO) || (xfer && (count == CNT_ONE))) nextState = DONE;
        DONE:    nextState = DONE;
        default: nextState = CAPTURE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.out_valid = drainValid;
    {bus.out_cycle, bus.out_pc, bus.out_instr, bus.out_a0} = mem[rdPtr];
    state_o = state;
  end

  // Pointers, occupancy, cycle stamp and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      cyc      <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (capture) begin
        wrPtr <= wrPtr + 1'b1;
        // A full ring drops its oldest entry to make room.
        if (count == CNT_FULL) begin
          rdPtr    <= rdPtr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end
      if ((state == CAPTURE) && (cyc != 16'hFFFF)) cyc <= cyc + 16'd1;
      if (wdFire) timeout <= 1'b1;
      if (xfer) begin
        rdPtr <= rdPtr + 1'b1;
        count <= count - CNT_ONE;
      end
    end
  end

  // Entry storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (rst_n && !restart && capture)
      mem[wrPtr] <= {cyc, bus.trig_pc, bus.trig_instr, bus.trig_a0};
  end
endmodule

// File: tb/tb_sr_trace_buf.sv
// Bench for sr_trace_buf: directed scenarios plus random traffic, checked each cycle
// against a queue-based model of the trace buffer.
module tb_sr_trace_buf;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int TO    = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        restart = 1'b0;
  logic [4:0]  count;
  logic        overflow;
  logic        timeout;
  logic [1:0]  state_o;

  sr_trace_if bus ();

  sr_trace_buf #(.DEPTH_LOG2(DL), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .freeze   (freeze),
    .restart  (restart),
    .count    (count),
    .overflow (overflow),
    .timeout  (timeout),
    .state_o  (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected buffer contents, oldest first, as {cycle, pc, instr, a0}
  logic [111:0] exp_q[$];
  int           m_cyc;
  bit           m_ovf;
  bit           m_to;
  int           m_state;   // 0 capture, 1 drain, 2 done
  int           n_checks = 0;
  int           n_fails  = 0;
  logic [31:0]  last_pc;
  logic [15:0]  last_cyc;

  task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    check("state_o", 112'(state_o), 112'(m_state));
    check("count", 112'(count), 112'(exp_q.size()));
    check("overflow", 112'(overflow), 112'(m_ovf));
    check("timeout", 112'(timeout), 112'(m_to));
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cyc = 0;
    m_ovf = 1'b0;
    m_to = 1'b0;
    m_state = 0;
  endtask

  // driver: one clock cycle with the given inputs, checked before and after the edge
  task automatic tick(input bit tv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] a0, input bit fr, input bit rs, input bit rdy);
    bit ev;
    bus.trig_valid = tv;
    bus.trig_pc    = pc;
    bus.trig_instr = instr;
    bus.trig_a0    = a0;
    freeze         = fr;
    restart        = rs;
    bus.out_ready  = rdy;
    #1;
    ev = (m_state == 1) && (exp_q.size() != 0);
    check("out_valid", 112'(bus.out_valid), 112'(ev));
    if (ev) check("out_entry", {bus.out_cycle, bus.out_pc, bus.out_instr, bus.out_a0}, exp_q[0]);
    @(posedge clk);
    if (rs) begin
      model_clear();
    end else if (m_state == 0) begin
      if (tv) begin
        exp_q.push_back({m_cyc[15:0], pc, instr, a0});
        if (exp_q.size() > DEPTH) begin
          void'(exp_q.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (TO != 0 && m_cyc == TO) begin
        m_to = 1'b1;
        m_state = 1;
      end else if (fr) begin
        m_state = 1;
      end
      if (m_cyc < 65535) m_cyc++;
    end else if (m_state == 1) begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_state = 2;
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.trig_valid = 1'b1;
    bus.out_ready = 1'b1;
    freeze = 1'b1;
    restart = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    rst_n = 1'b1;
    bus.trig_valid = 1'b0;
    freeze = 1'b0;
    check_regs();
    check("rst_out_valid", 112'(bus.out_valid), 112'(0));
  endtask

  task automatic capture_n(input int n, input int pc_base);
    for (int i = 0; i < n; i++)
      tick(1'b1, 32'(pc_base + 4 * i), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0; mode 2: random ready
  task automatic drain(input int mode, input int budget);
    bit rdy;
    for (int i = 0; i < budget; i++) begin
      if (m_state != 1) break;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
      if (bus.out_valid && rdy) begin
        last_pc  = bus.out_pc;
        last_cyc = bus.out_cycle;
      end
      tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
    end
    check("drain_done_state", 112'(state_o), 112'(2));
  endtask

  initial begin
    bus.trig_valid = 1'b0;
    bus.trig_pc    = '0;
    bus.trig_instr = '0;
    bus.trig_a0    = '0;
    bus.out_ready  = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // 1: five retires, freeze, full-speed drain
    capture_n(5, 0);
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t1_count", 112'(count), 112'(5));
    check("t1_state", 112'(state_o), 112'(1));
    check("t1_first_cycle", 112'(bus.out_cycle), 112'(0));
    drain(0, 10);
    check("t1_last_pc", 112'(last_pc), 112'(32'h10));
    check("t1_last_cycle", 112'(last_cyc), 112'(4));
    check("t1_overflow", 112'(overflow), 112'(0));

    // 2: twenty retires wrap the ring
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    capture_n(20, 0);
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t2_count", 112'(count), 112'(16));
    check("t2_overflow", 112'(overflow), 112'(1));
    check("t2_first_pc", 112'(bus.out_pc), 112'(32'h10));
    drain(2, 80);
    check("t2_last_pc", 112'(last_pc), 112'(32'h4C));

    // 3 + 4: watchdog freeze, then a drain with toggling ready
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 130; i++) begin
      if (m_state != 0) break;
      tick(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    end
    check("t3_state", 112'(state_o), 112'(1));
    check("t3_timeout", 112'(timeout), 112'(1));
    check("t3_count", 112'(count), 112'(16));
    check("t3_first_cycle", 112'(bus.out_cycle), 112'(105));
    drain(1, 40);
    check("t3_last_cycle", 112'(last_cyc), 112'(120));

    // 5: reset in the middle of a drain
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    capture_n(8, 32'h100);
    tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t5_count_pre", 112'(count), 112'(8));
    do_reset();
    check("t5_state", 112'(state_o), 112'(0));
    check("t5_count", 112'(count), 112'(0));

    // 6: restart beats freeze and the sample of the same cycle
    capture_n(3, 32'h200);
    tick(1'b1, 32'hDEAD, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
    check("t6_state", 112'(state_o), 112'(0));
    check("t6_count", 112'(count), 112'(0));
    tick(1'b1, 32'hABC, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
    check("t6_pc", 112'(bus.out_pc), 112'(32'hABC));
    check("t6_cycle", 112'(bus.out_cycle), 112'(0));
    drain(0, 5);

    // random traffic
    for (int r = 0; r < 4; r++) begin
      tick(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 90; i++)
        tick(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/sr_trace_buf.md
Name: sr_trace_buf

Overview:
- Synthesizable retire-trace capture stage, placed downstream of sr_cpu, inside sm_top.
- Samples a per-cycle stamp on each retiring instruction: cycle, pc, instr, a0.
- Keeps the last 2^DEPTH_LOG2 entries in a circular buffer.
- Freezes on watchdog timeout or on software request, then drains oldest-first over a valid/ready port to a UART or debug reader.

Parameters:
DEPTH_LOG2, 4, log2 of buffer depth (16 entries)
TIMEOUT_CYCLES, 120, capture-cycle index that triggers freeze; 0 disables the watchdog

Ports:
clk  in  1  system clock (CPU clock domain)
rst_n  in  1  reset, synchronous, active-low
trig_valid  in  1  instruction retires this cycle
trig_pc  in  32  pc of the retiring instruction
trig_instr  in  32  instruction word
trig_a0  in  32  register x10 value at retire
freeze  in  1  request to stop capture and begin drain
restart  in  1  clear buffer and resume capture
out_valid  out  1  drain entry available
out_ready  in  1  consumer accepts entry
out_cycle  out  16  cycle stamp of entry
out_pc  out  32  pc of entry
out_instr  out  32  instr of entry
out_a0  out  32  a0 of entry
count  out  DEPTH_LOG2+1  entries held
overflow  out  1  sticky: at least one entry overwritten
timeout  out  1  sticky: watchdog fired
state_o  out  2  CAPTURE=0, DRAIN=1, DONE=2

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state=CAPTURE; wr_ptr, rd_ptr, count and cyc all 0.
  - overflow=0, timeout=0, out_valid=0.
  - Memory contents don't-care.
  - Reset overrides all other inputs, including a reset mid-drain.
- Reset is released only at the first edge where rst_n=1; no sampling happens on a reset edge.
- CAPTURE, every clock:
  - If trig_valid: write {cyc, pc, instr, a0} at wr_ptr and advance wr_ptr modulo depth.
    - count<depth: count+1.
    - count==depth: rd_ptr also advances (oldest lost), count unchanged, overflow<=1.
  - cyc increments, saturating at 16'hFFFF.
  - Watchdog: if TIMEOUT_CYCLES!=0 and cyc==TIMEOUT_CYCLES, set timeout<=1 and next state=DRAIN.
  - freeze=1 also gives next state=DRAIN.
  - The sample presented in the transition cycle is still captured.
  - freeze and timeout in the same cycle: DRAIN, timeout=1.
- DRAIN:
  - No capture; trig_* ignored; cyc holds.
  - out_valid = (count!=0); out_* are combinational reads at rd_ptr.
  - Transfer when out_valid && out_ready: rd_ptr advances modulo depth, count-1.
  - When count reaches 0 (or is 0 on entry), next state=DONE.
  - out_ready while out_valid=0 has no effect.
- DONE: out_valid=0; waits for restart.
- restart (any state, lower priority than rst_n):
  - Next cycle: state=CAPTURE; pointers, count, cyc, overflow and timeout cleared.
  - restart has priority over freeze and over capture in the same cycle; that cycle's sample is discarded.
- Pointer and count arithmetic:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - count never exceeds 2^DEPTH_LOG2.
- Latency:
  - A captured entry is readable one cycle after the capture edge.
  - out_valid rises in the first cycle state_o=DRAIN.

Test Plan:
1. Reset, 5 retires (pc=0,4,8,C,10), then freeze. Expect count=5, DRAIN; drain with out_ready=1 yields pc 0..10 with out_cycle 0..4; state DONE after 5 transfers; overflow=0.
2. 20 consecutive retires (pc=4*i), then freeze. Expect count=16, overflow=1; first drained pc=0x10 (i=4), last pc=0x4C.
3. TIMEOUT_CYCLES=120, trig_valid=1 every cycle, no freeze. Expect timeout=1 and state DRAIN after the edge where cyc==120; count=16; last entry out_cycle=120.
4. Drain with out_ready toggling 1,0,1,0. Expect one transfer per ready-high cycle; out_* stable while out_valid=1 and out_ready=0.
5. rst_n=0 for 1 cycle with count=8 in DRAIN. Expect count=0, out_valid=0, state CAPTURE, overflow=0, timeout=0.
6. restart and freeze together in CAPTURE with trig_valid=1. Expect state CAPTURE, count=0, cyc=0; the sample is not stored.
